// File: rtl/sonar_scan_scheduler.sv
// Round-robin ultrasonic ranging scheduler: fires one HC-SR04-style sensor at a
// time, times its echo in microseconds, converts it to centimetres by counting
// 58 us buckets, and publishes a one-cycle report plus a per-sensor distance bank.
module sonar_scan_scheduler #(
  parameter int NUM_SENSORS   = 4,
  parameter int CYCLES_PER_US = 50,
  parameter int TRIG_US       = 10,
  parameter int ECHO_WAIT_US  = 1000,
  parameter int MAX_ECHO_US   = 30000,
  parameter int GAP_US        = 10000,
  parameter int US_PER_CM     = 58
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_SENSORS-1:0]      echo,
  output logic [NUM_SENSORS-1:0]      trig,
  output logic                        busy,
  output logic                        rpt_valid,
  output logic [2:0]                  rpt_id,
  output logic [15:0]                 rpt_cm,
  output logic                        rpt_timeout,
  output logic [16*NUM_SENSORS-1:0]   dist_bank
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    REPORT,
    GAP
  } state_t;

  state_t state, state_next;

  logic [NUM_SENSORS-1:0] echo_s1, echo_s2;
  logic        echo_sel, echo_prev, echo_rise, echo_fall;
  logic [15:0] presc, tick_cnt;
  logic        tick;
  logic [15:0] us_cnt, cm_cnt, sub_cnt, meas_cm;
  logic [2:0]  idx;
  logic [15:0] res_cm;
  logic        res_timeout;

  assign tick      = (presc == 16'(CYCLES_PER_US - 1));
  assign echo_rise = echo_sel & ~echo_prev;
  assign echo_fall = ~echo_sel & echo_prev;
  assign busy      = (state != IDLE);
  // A tick landing on the falling-edge cycle still counts toward the distance.
  assign meas_cm   = (tick && sub_cnt == 16'(US_PER_CM - 1)) ? cm_cnt + 16'd1 : cm_cnt;

  // Select the synchronised echo of the active sensor and decode the trigger bank.
  always_comb begin
    echo_sel = 1'b0;
    trig     = '0;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      if (idx == 3'(k)) begin
        echo_sel = echo_s2[k];
        trig[k]  = (state == TRIG);
      end
    end
  end

  // Next-state logic and the result that will be published on entry to REPORT.
  always_comb begin
    state_next  = state;
    res_cm      = 16'hFFFF;
    res_timeout = 1'b1;
    case (state)
      IDLE: begin
        if (enable) state_next = TRIG;
      end
      TRIG: begin
        if (tick && tick_cnt == 16'(TRIG_US - 1)) state_next = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        if (echo_rise) state_next = MEASURE;
        else if (tick && tick_cnt == 16'(ECHO_WAIT_US - 1)) state_next = REPORT;
      end
      MEASURE: begin
        if (echo_fall) begin
          state_next  = REPORT;
          res_cm      = meas_cm;
          res_timeout = 1'b0;
        end else if (us_cnt >= 16'(MAX_ECHO_US)) begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        state_next = GAP;
      end
      GAP: begin
        if (tick && tick_cnt == 16'(GAP_US - 1)) state_next = enable ? TRIG : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and round-robin sensor index, advanced as GAP ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_next;
      if (state == GAP && state_next != GAP)
        idx <= (idx == 3'(NUM_SENSORS - 1)) ? 3'd0 : idx + 3'd1;
    end
  end

  // Two-flop echo synchronisers plus the previous selected value for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      echo_s1   <= '0;
      echo_s2   <= '0;
      echo_prev <= 1'b0;
    end else begin
      echo_s1   <= echo;
      echo_s2   <= echo_s1;
      echo_prev <= echo_sel;
    end
  end

  // Microsecond prescaler and per-state tick counter, both restarted on every state entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc    <= 16'd0;
      tick_cnt <= 16'd0;
    end else if (state_next != state) begin
      presc    <= 16'd0;
      tick_cnt <= 16'd0;
    end else if (tick) begin
      presc    <= 16'd0;
      tick_cnt <= tick_cnt + 16'd1;
    end else begin
      presc    <= presc + 16'd1;
    end
  end

  // Echo width in us and divider-free cm conversion via a 0..US_PER_CM-1 sub-counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      us_cnt  <= 16'd0;
      cm_cnt  <= 16'd0;
      sub_cnt <= 16'd0;
    end else if (state == WAIT_ECHO && state_next == MEASURE) begin
      us_cnt  <= 16'd0;
      cm_cnt  <= 16'd0;
      sub_cnt <= 16'd0;
    end else if (state == MEASURE && tick) begin
      us_cnt <= us_cnt + 16'd1;
      if (sub_cnt == 16'(US_PER_CM - 1)) begin
        sub_cnt <= 16'd0;
        cm_cnt  <= cm_cnt + 16'd1;
      end else begin
        sub_cnt <= sub_cnt + 16'd1;
      end
    end
  end

  // Report outputs and distance bank are written on the edge entering REPORT and hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_valid   <= 1'b0;
      rpt_id      <= 3'd0;
      rpt_cm      <= 16'd0;
      rpt_timeout <= 1'b0;
      dist_bank   <= '0;
    end else begin
      rpt_valid <= (state_next == REPORT);
      if (state_next == REPORT) begin
        rpt_id      <= idx;
        rpt_cm      <= res_cm;
        rpt_timeout <= res_timeout;
        for (int k = 0; k < NUM_SENSORS; k++) begin
          if (idx == 3'(k)) dist_bank[16*k +: 16] <= res_cm;
        end
      end
    end
  end

endmodule

// File: tb/tb_sonar_scan_scheduler.sv
// Scoreboard bench for sonar_scan_scheduler: behavioural echo responders per
// sensor, expected reports queued by the stimulus, popped by a report monitor.
module tb_sonar_scan_scheduler;

  localparam int NS           = 4;
  localparam int CPU          = 2;
  localparam int TRIG_US      = 10;
  localparam int ECHO_WAIT_US = 300;
  localparam int MAX_ECHO_US  = 2000;
  localparam int GAP_US       = 200;
  localparam int US_PER_CM    = 58;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  wire  [NS-1:0]     echo;
  logic [NS-1:0]     trig;
  logic              busy;
  logic              rpt_valid;
  logic [2:0]        rpt_id;
  logic [15:0]       rpt_cm;
  logic              rpt_timeout;
  logic [16*NS-1:0]  dist_bank;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] cm;
    logic        to;
  } rpt_t;

  rpt_t exp_q[$];
  int   assert_cnt = 0;
  int   fail_cnt   = 0;

  int          echo_delay[NS];
  int          echo_width[NS];
  bit          echo_on[NS];
  logic [NS-1:0] stuck_high = '0;

  int  cyc = 0;
  int  trig_w = 0;
  int  last_rise = 0;
  bit  skip_gap = 1'b1;
  bit  overlap = 1'b0;

  sonar_scan_scheduler #(
    .NUM_SENSORS   (NS),
    .CYCLES_PER_US (CPU),
    .TRIG_US       (TRIG_US),
    .ECHO_WAIT_US  (ECHO_WAIT_US),
    .MAX_ECHO_US   (MAX_ECHO_US),
    .GAP_US        (GAP_US),
    .US_PER_CM     (US_PER_CM)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .echo        (echo),
    .trig        (trig),
    .busy        (busy),
    .rpt_valid   (rpt_valid),
    .rpt_id      (rpt_id),
    .rpt_cm      (rpt_cm),
    .rpt_timeout (rpt_timeout),
    .dist_bank   (dist_bank)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input bit on, input int delay_us, input int width_us, input bit stuck);
    echo_on[k]    = on;
    echo_delay[k] = delay_us;
    echo_width[k] = width_us;
    stuck_high[k] = stuck;
  endtask

  task automatic expectReport(input int id, input int cm, input bit to);
    rpt_t r;
    r.id = 3'(id);
    r.cm = 16'(cm);
    r.to = to;
    exp_q.push_back(r);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput({name, "_all_reports_seen"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic waitTrig(input string name, input int k, input logic level, input int budget);
    int n = 0;
    while (trig[k] !== level && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(trig[k]), 32'(level));
  endtask

  // Each sensor answers its own trigger falling edge with a delayed echo pulse.
  for (genvar k = 0; k < NS; k++) begin : g_resp
    logic pulse;
    assign echo[k] = pulse | stuck_high[k];
    initial begin
      pulse = 1'b0;
      forever begin
        @(negedge trig[k]);
        if (!reset && echo_on[k]) begin
          repeat (echo_delay[k] * CPU) @(negedge clock);
          pulse = 1'b1;
          repeat (echo_width[k] * CPU) @(negedge clock);
          pulse = 1'b0;
        end
      end
    end
  end

  // Monitor: trigger width/spacing/exclusivity and scoreboard comparison of every report.
  always @(negedge clock) begin
    rpt_t e;
    cyc++;
    if (reset) begin
      trig_w   = 0;
      skip_gap = 1'b1;
    end else begin
      if (!$onehot0(trig)) overlap = 1'b1;
      if (trig != '0) begin
        if (trig_w == 0) begin
          if (!skip_gap) checkOutput("trig_spacing_ge_gap", 32'(cyc - last_rise >= GAP_US * CPU), 32'd1);
          last_rise = cyc;
          skip_gap  = 1'b0;
        end
        trig_w++;
      end else if (trig_w != 0) begin
        checkOutput("trig_width_cycles", 32'(trig_w), 32'(TRIG_US * CPU));
        trig_w = 0;
      end
      if (rpt_valid) begin
        if (exp_q.size() == 0) begin
          assert_cnt++;
          fail_cnt++;
          $display("[TB] FAIL unexpected_report: got id %0d cm %0h, expected none", rpt_id, rpt_cm);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rpt_id", 32'(rpt_id), 32'(e.id));
          checkOutput("rpt_cm", 32'(rpt_cm), 32'(e.cm));
          checkOutput("rpt_timeout", 32'(rpt_timeout), 32'(e.to));
          checkOutput("dist_bank_slice", 32'(dist_bank[16*e.id +: 16]), 32'(e.cm));
        end
      end
    end
  end

  // Watchdog so a stuck design can never hang the run.
  initial begin
    repeat (90000) @(posedge clock);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    logic [NS-1:0] trig_seen;
    int n;
    for (int k = 0; k < NS; k++) applyStimulus(k, 1'b1, 20, 116, 1'b0);

    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_trig", 32'(trig), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rpt_valid", 32'(rpt_valid), 32'd0);
    checkOutput("reset_rpt_cm", 32'(rpt_cm), 32'd0);
    checkOutput("reset_dist_bank", 32'(dist_bank != '0), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idle_busy_disabled", 32'(busy), 32'd0);

    $display("[TB] normal measurement and round-robin order");
    applyStimulus(0, 1'b1, 20, 580, 1'b0);
    expectReport(0, 10, 1'b0);
    expectReport(1, 2, 1'b0);
    expectReport(2, 2, 1'b0);
    expectReport(3, 2, 1'b0);
    enable = 1'b1;
    waitDrain("rr_first_pass", 20000);
    applyStimulus(0, 1'b1, 20, 116, 1'b0);
    expectReport(0, 2, 1'b0);
    waitDrain("rr_wrap", 5000);

    $display("[TB] stuck-high, missing and over-length echoes");
    applyStimulus(1, 1'b0, 0, 0, 1'b1);
    applyStimulus(2, 1'b0, 0, 0, 1'b0);
    applyStimulus(3, 1'b1, 20, 2500, 1'b0);
    expectReport(1, 16'hFFFF, 1'b1);
    expectReport(2, 16'hFFFF, 1'b1);
    expectReport(3, 16'hFFFF, 1'b1);
    waitDrain("timeouts", 20000);

    $display("[TB] enable dropped during trigger of sensor 1");
    applyStimulus(1, 1'b1, 20, 116, 1'b0);
    applyStimulus(2, 1'b1, 20, 116, 1'b0);
    expectReport(0, 2, 1'b0);
    expectReport(1, 2, 1'b0);
    waitTrig("trig1_rises", 1, 1'b1, 5000);
    enable = 1'b0;
    waitDrain("enable_drop", 5000);
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("enable_drop_busy", 32'(busy), 32'd0);
    trig_seen = '0;
    repeat (600) begin
      @(negedge clock);
      trig_seen = trig_seen | trig;
    end
    checkOutput("enable_drop_no_trig", 32'(trig_seen), 32'd0);

    $display("[TB] reset during measurement");
    applyStimulus(2, 1'b1, 20, 580, 1'b0);
    enable = 1'b1;
    waitTrig("trig2_rises", 2, 1'b1, 2000);
    waitTrig("trig2_falls", 2, 1'b0, 2000);
    repeat (200) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_trig", 32'(trig), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_rpt_valid", 32'(rpt_valid), 32'd0);
    checkOutput("midreset_dist_bank", 32'(dist_bank != '0), 32'd0);
    expectReport(0, 2, 1'b0);
    reset = 1'b0;
    waitDrain("restart_sensor0", 5000);

    checkOutput("no_trig_overlap", 32'(overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
